// File: rtl/breath_pkg.sv
// Shared constants and FSM state codes for the breathing-LED PWM controller.
package breath_pkg;

   localparam int unsigned PHASE_W = 3;
   localparam int unsigned BOUND_W = 8;

   typedef enum logic [PHASE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_RISE    = 3'd1,
      ST_HOLD_HI = 3'd2,
      ST_FALL    = 3'd3,
      ST_HOLD_LO = 3'd4
   } state_t;

endpackage

// File: rtl/breath_boundary_det.sv
// Detects the PWM period boundary: the pair's phase flag falling from off-count (1) to on-count (0).
module breath_boundary_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pwm_state,
   output logic o_boundary
);

   logic r_prev_state;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_prev_state <= 1'b0;
      else        r_prev_state <= i_pwm_state;
   end

   assign o_boundary = r_prev_state & ~i_pwm_state;

endmodule

// File: rtl/breath_ctrl.sv
// Breathing-LED duty sequencer driving the upper bounds of a two-counter PWM pair.
// Define BREATH_GAMMA_EN for a squared (gamma) duty map instead of a linear one.
module breath_ctrl
   import breath_pkg::*;
#(
   parameter int unsigned PERIOD   = 200,
   parameter int unsigned MIN_DUTY = 0,
   parameter int unsigned MAX_DUTY = 200,
   parameter int unsigned STEP     = 4,
   parameter int unsigned REPEAT   = 2,
   parameter int unsigned HOLD     = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_pwm_state,
   output logic [BOUND_W-1:0] o_ub1,
   output logic [BOUND_W-1:0] o_ub2,
   output logic [PHASE_W-1:0] o_phase,
   output logic               o_busy,
   output logic               o_cycle_done
);

   function automatic logic [BOUND_W-1:0] map_duty(input logic [BOUND_W-1:0] d);
`ifdef BREATH_GAMMA_EN
      logic [2*BOUND_W-1:0] prod;
      prod     = {{BOUND_W{1'b0}}, d} * {{BOUND_W{1'b0}}, d};
      map_duty = prod[2*BOUND_W-1:BOUND_W];
`else
      map_duty = d;
`endif
   endfunction

   localparam logic [BOUND_W-1:0] DUTY_MIN  = BOUND_W'(MIN_DUTY);
   localparam logic [BOUND_W-1:0] DUTY_MAX  = BOUND_W'(MAX_DUTY);
   localparam logic [BOUND_W-1:0] STEP_B    = BOUND_W'(STEP);
   localparam logic [BOUND_W-1:0] PERIOD_B  = BOUND_W'(PERIOD);
   localparam logic [BOUND_W-1:0] REP_LAST  = BOUND_W'(REPEAT - 1);
   localparam logic [BOUND_W-1:0] HOLD_LAST = BOUND_W'(HOLD - 1);
   localparam logic [BOUND_W-1:0] UB1_RST   = map_duty(DUTY_MIN);
   localparam logic [BOUND_W-1:0] UB2_RST   = PERIOD_B - UB1_RST;

   logic               w_boundary;
   state_t             r_state, w_state_nxt;
   logic [BOUND_W-1:0] r_duty, w_duty_nxt;
   logic [BOUND_W-1:0] r_rep_cnt, w_rep_nxt;
   logic [BOUND_W-1:0] r_hold_cnt, w_hold_nxt;
   logic [BOUND_W-1:0] r_ub1, r_ub2, w_ub1_nxt, w_ub2_nxt;
   logic               r_cycle_done, w_done_nxt;
   logic [BOUND_W:0]   w_up;

   breath_boundary_det u_bdet (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_pwm_state (i_pwm_state),
      .o_boundary  (w_boundary)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= ST_IDLE;
         r_duty       <= DUTY_MIN;
         r_rep_cnt    <= '0;
         r_hold_cnt   <= '0;
         r_ub1        <= UB1_RST;
         r_ub2        <= UB2_RST;
         r_cycle_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_duty       <= w_duty_nxt;
         r_rep_cnt    <= w_rep_nxt;
         r_hold_cnt   <= w_hold_nxt;
         r_ub1        <= w_ub1_nxt;
         r_ub2        <= w_ub2_nxt;
         r_cycle_done <= w_done_nxt;
      end
   end

   // Everything holds between boundaries; only the done pulse self-clears.
   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_rep_nxt   = r_rep_cnt;
      w_hold_nxt  = r_hold_cnt;
      w_done_nxt  = 1'b0;
      w_up        = {1'b0, r_duty} + {1'b0, STEP_B};
      if (w_boundary) begin
         if ((r_state != ST_IDLE) && !i_en) begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = DUTY_MIN;
            w_rep_nxt   = '0;
            w_hold_nxt  = '0;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (i_en) begin
                     w_state_nxt = ST_RISE;
                     w_rep_nxt   = '0;
                  end
               end
               ST_RISE: begin
                  if (r_rep_cnt == REP_LAST) begin
                     w_rep_nxt  = '0;
                     w_duty_nxt = (w_up >= {1'b0, DUTY_MAX}) ? DUTY_MAX : w_up[BOUND_W-1:0];
                     if (w_duty_nxt == DUTY_MAX) w_state_nxt = ST_HOLD_HI;
                  end else begin
                     w_rep_nxt = r_rep_cnt + 1'b1;
                  end
               end
               ST_HOLD_HI: begin
                  if (r_hold_cnt == HOLD_LAST) begin
                     w_hold_nxt  = '0;
                     w_state_nxt = ST_FALL;
                  end else begin
                     w_hold_nxt = r_hold_cnt + 1'b1;
                  end
               end
               ST_FALL: begin
                  if (r_rep_cnt == REP_LAST) begin
                     w_rep_nxt  = '0;
                     w_duty_nxt = ({1'b0, r_duty} >= ({1'b0, DUTY_MIN} + {1'b0, STEP_B})) ?
                                  (r_duty - STEP_B) : DUTY_MIN;
                     if (w_duty_nxt == DUTY_MIN) w_state_nxt = ST_HOLD_LO;
                  end else begin
                     w_rep_nxt = r_rep_cnt + 1'b1;
                  end
               end
               ST_HOLD_LO: begin
                  if (r_hold_cnt == HOLD_LAST) begin
                     w_hold_nxt  = '0;
                     w_rep_nxt   = '0;
                     w_done_nxt  = 1'b1;
                     w_state_nxt = ST_RISE;
                  end else begin
                     w_hold_nxt = r_hold_cnt + 1'b1;
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_duty_nxt  = DUTY_MIN;
                  w_rep_nxt   = '0;
                  w_hold_nxt  = '0;
               end
            endcase
         end
      end
      w_ub1_nxt = w_boundary ? map_duty(w_duty_nxt) : r_ub1;
      w_ub2_nxt = PERIOD_B - w_ub1_nxt;
   end

   assign o_ub1        = r_ub1;
   assign o_ub2        = r_ub2;
   assign o_phase      = r_state;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_cycle_done = r_cycle_done;

endmodule

// File: tb/tb_breath_ctrl.sv
// Directed self-checking bench for breath_ctrl (defaults plus a STEP=7 instance sharing stimulus).
module tb_breath_ctrl;

   logic       clk = 1'b0;
   logic       rst, en, pwm;
   logic [7:0] ub1, ub2, ub1_7, ub2_7;
   logic [2:0] phase, phase_7;
   logic       busy, done, busy_7, done_7;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int sum_bad  = 0;

   always #5 clk = ~clk;

   breath_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_pwm_state(pwm),
      .o_ub1(ub1), .o_ub2(ub2), .o_phase(phase), .o_busy(busy), .o_cycle_done(done)
   );

   breath_ctrl #(.STEP(7)) dut7 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_pwm_state(pwm),
      .o_ub1(ub1_7), .o_ub2(ub2_7), .o_phase(phase_7), .o_busy(busy_7), .o_cycle_done(done_7)
   );

   function automatic int mapd(input int d);
`ifdef BREATH_GAMMA_EN
      return (d * d) >> 8;
`else
      return d;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One PWM period: off-count then on-count; boundary lands on the middle posedge.
   task automatic pulse();
      @(negedge clk) pwm = 1'b1;
      @(negedge clk) pwm = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; en = 1'b0; pwm = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ub1",   ub1,   mapd(0));
      check("rst_ub2",   ub2,   200 - mapd(0));
      check("rst_phase", phase, 0);
      check("rst_busy",  busy,  0);
      check("rst_done",  done,  0);
      check("rst_ub2_7", ub2_7, 200 - mapd(0));

      @(negedge clk);
      rst = 1'b1; en = 1'b1;
      pulse();
      check("b1_phase", phase, 1);
      check("b1_busy",  busy,  1);
      check("b1_ub1",   ub1,   mapd(0));
      pulse();
      pulse();
      check("b3_ub1",   ub1,   mapd(4));
      check("b3_ub2",   ub2,   200 - mapd(4));
      check("b3_phase", phase, 1);

      repeat (10) @(negedge clk);
      check("idle_hold_ub1",   ub1,   mapd(4));
      check("idle_hold_phase", phase, 1);

      for (int b = 4; b <= 365; b++) begin
         pulse();
         if (int'(ub1) + int'(ub2) != 200) sum_bad++;
         if (done) done_cnt++;
         if (b == 57) begin
            check("s7_pre_ub1",   ub1_7,   mapd(196));
            check("s7_pre_phase", phase_7, 1);
         end
         if (b == 59) begin
            check("s7_clamp_ub1",   ub1_7,   mapd(200));
            check("s7_clamp_ub2",   ub2_7,   200 - mapd(200));
            check("s7_clamp_phase", phase_7, 2);
         end
         if (b == 65) begin
            check("d128_ub1", ub1, mapd(128));
            check("d128_ub2", ub2, 200 - mapd(128));
         end
         if (b == 101) begin
            check("top_phase", phase, 2);
            check("top_ub1",   ub1,   mapd(200));
         end
         if (b == 109) check("fall_phase", phase, 3);
         if (b == 209) begin
            check("bot_phase", phase, 4);
            check("bot_ub1",   ub1,   mapd(0));
         end
         if (b == 216) check("pre_done", done, 0);
         if (b == 217) begin
            check("done_hi",    done,  1);
            check("done_phase", phase, 1);
            @(negedge clk);
            check("done_width", done, 0);
         end
      end
      check("done_count", done_cnt, 1);
      check("sum_period", sum_bad,  0);
      check("d120_phase", phase, 3);
      check("d120_ub1",   ub1,   mapd(120));

      en = 1'b0;
      pulse();
      check("abort_phase", phase, 0);
      check("abort_ub1",   ub1,   mapd(0));
      check("abort_ub2",   ub2,   200 - mapd(0));
      check("abort_done",  done,  0);
      check("abort_busy",  busy,  0);

      en = 1'b1;
      repeat (5) pulse();
      check("mid_rise_ub1",   ub1,   mapd(8));
      check("mid_rise_phase", phase, 1);
      rst = 1'b0;
      #1;
      check("async_phase", phase, 0);
      check("async_ub1",   ub1,   mapd(0));
      check("async_ub2",   ub2,   200 - mapd(0));
      check("async_busy",  busy,  0);
      check("async_done",  done,  0);
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
